// File: rtl/btn_repeat.sv
// Two-channel push-button front end: synchronize, debounce on a shared
// sample tick, and emit press / hold-to-repeat event pulses per channel.
module btn_repeat #(
  parameter int SAMPLE_DIV   = 125000,
  parameter int STABLE_CNT   = 20,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] BTNIN,
  output logic [1:0] LEVEL,
  output logic [1:0] PRESS
);

  localparam int TW   = $clog2(SAMPLE_DIV);
  localparam int SW   = $clog2(STABLE_CNT + 1);
  localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ?
                        HOLD_TICKS : REPEAT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS - 1);

  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [TW-1:0] tcnt;
  logic          tick;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= BTNIN;
      sync_b <= sync_a;
    end
  end

  assign tick = (tcnt == TICK_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_ch
    typedef enum logic [1:0] {
      IDLE,
      WAIT_HOLD,
      REPEAT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] stable;
    logic [SW-1:0] stable_nx;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_nx;
    logic          lvl_q;
    logic          lvl_nx;
    logic          press_q;
    logic          press_nx;

    always_ff @(posedge CLK) begin
      if (RST) begin
        state   <= IDLE;
        stable  <= '0;
        hold    <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
      end else begin
        state   <= state_nx;
        stable  <= stable_nx;
        hold    <= hold_nx;
        lvl_q   <= lvl_nx;
        press_q <= press_nx;
      end
    end

    // Debounce: only a full run of differing samples flips the level.
    always_comb begin
      stable_nx = stable;
      lvl_nx    = lvl_q;
      if (tick) begin
        if (sync_b[i] != lvl_q) begin
          if (stable == STAB_LAST) begin
            lvl_nx    = sync_b[i];
            stable_nx = '0;
          end else begin
            stable_nx = stable + 1'b1;
          end
        end else begin
          stable_nx = '0;
        end
      end
    end

    // Release is checked first so it beats a repeat on the same tick.
    always_comb begin
      state_nx = state;
      hold_nx  = hold;
      press_nx = 1'b0;
      unique case (state)
        IDLE: begin
          if (!lvl_q && lvl_nx) begin
            press_nx = 1'b1;
            state_nx = WAIT_HOLD;
            hold_nx  = '0;
          end
        end
        WAIT_HOLD: begin
          if (!lvl_q) begin
            state_nx = IDLE;
            hold_nx  = '0;
          end else if (tick) begin
            if (hold == HOLD_LAST) begin
              press_nx = 1'b1;
              state_nx = REPEAT;
              hold_nx  = '0;
            end else begin
              hold_nx = hold + 1'b1;
            end
          end
        end
        REPEAT: begin
          if (!lvl_q) begin
            state_nx = IDLE;
            hold_nx  = '0;
          end else if (tick) begin
            if (hold == REP_LAST) begin
              press_nx = 1'b1;
              hold_nx  = '0;
            end else begin
              hold_nx = hold + 1'b1;
            end
          end
        end
        default: begin
          state_nx = IDLE;
          hold_nx  = '0;
        end
      endcase
    end

    assign LEVEL[i] = lvl_q;
    assign PRESS[i] = press_q;
  end

endmodule
